l1_refill_arbiter: RTL and testbench
====================================

# l1_refill_arbiter

Shares the single external memory port between the L1 instruction-cache refill engine and the L1 data-cache miss/writeback engine. The instruction-cache engine is the one that feeds the fetch stage. The block arbitrates whole cache-line bursts with two-way round-robin fairness. It sequences the per-beat handshake with a beat counter and routes read data and completion back to the owning requester. It sits between the L1 caches and the core-top memory interface.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, width of one beat
- BEATS, 8, beats per cache line; power of two, at least 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  I-cache refill request; held until i_done
- i_addr  in  ADDR_WIDTH  I-cache line address; stable while i_req
- i_rvalid  out  1  read beat valid for the I-cache
- i_rdata  out  DATA_WIDTH  read beat data
- i_done  out  1  one-cycle pulse when the I-cache burst completes
- d_req  in  1  D-cache request; held until d_done
- d_we  in  1  1 = writeback burst, 0 = refill read
- d_addr  in  ADDR_WIDTH  D-cache line address; stable while d_req
- d_wdata  in  DATA_WIDTH  current write beat
- d_wready  out  1  current write beat consumed; requester advances
- d_rvalid  out  1  read beat valid for the D-cache
- d_rdata  out  DATA_WIDTH  read beat data
- d_done  out  1  one-cycle completion pulse
- m_req  out  1  burst active
- m_we  out  1  burst direction
- m_addr  out  ADDR_WIDTH  line-aligned burst base address
- m_wdata  out  DATA_WIDTH  write beat
- m_ready  in  1  write beat accepted this cycle
- m_rvalid  in  1  read beat returned this cycle
- m_rdata  in  DATA_WIDTH  read beat data

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE, arbitration:**
  - Only one requester asserting wins.
  - If both assert, the requester not granted last wins.
  - last_owner resets to D, so I wins the first tie.
- **IDLE, on grant:**
  - Register the owner, m_we (= d_we for D, 0 for I) and m_addr.
  - m_addr = request address with the low log2(BEATS*DATA_WIDTH/8) bits cleared.
  - Clear beat_cnt; go to BUSY.
- **BUSY, outputs:**
  - m_req = 1.
  - m_wdata = d_wdata.
  - d_wready = m_ready && m_we.
  - Owner's rvalid = m_rvalid && !m_we; its rdata = m_rdata (combinational pass-through).
  - The non-owner's rvalid = 0.
- **BUSY, beat counting:**
  - A beat counts on m_ready (write) or m_rvalid (read); beat_cnt increments.
  - The last beat (beat_cnt == BEATS-1) moves the FSM to DONE.
  - Beats on the ignored strobe are discarded.
- **DONE:**
  - Owner's done = 1 for exactly one cycle; m_req = 0.
  - Update last_owner; return to IDLE.
  - Requests are not sampled in DONE.
- **Requester rule:** drop req the cycle after done. A req still high in IDLE is a new request.
- **beat_cnt width:** log2(BEATS) bits; it wraps to 0 on the last beat.

## Timing
- **Reset values:** FSM = IDLE, last_owner = D, beat_cnt = 0, every output = 0.
- **Reset mid-burst:** the burst aborts immediately with no done pulse. The memory side is reset by the same rst.
- **Grant latency:** req rising in IDLE gives m_req = 1 on the next cycle.
- **Completion latency:** the last beat at cycle t gives done at t+1 and IDLE at t+2. The earliest next m_req is t+3.
- **Minimum burst:** BEATS+2 cycles, from m_req rise to the cycle after done.
- **Zero-wait memory:** one beat per cycle is sustained.
- **Simultaneous events:** both req rising in the same IDLE cycle resolves by round-robin. Under continuous contention the requesters strictly alternate.
- **Outside BUSY:** m_rvalid and m_ready are ignored.

## Structure
- **Shared L1 cache package:**
  - arb_state_t (IDLE/BUSY/DONE).
  - arb_owner_t (OWNER_I/OWNER_D).
  - BEATS and the line-offset width constant, shared with the cache refill engines.
- **Sub-module rr_arbiter2:** two requests, a registered last-owner bit updated on an enable strobe, and a one-hot grant output.
- **Top level:** FSM, beat counter and data routing.

## Test plan
- **Single I refill:** i_req, i_addr=0x0000_1234, m_rvalid every cycle with data 0..7.
  - m_addr = 0x0000_1220 one cycle after i_req.
  - Eight i_rvalid beats with data 0..7, i_done the cycle after beat 7.
  - d_rvalid stays 0.
- **D writeback with stalls:** d_we=1, m_ready toggling 1,0,1,...
  - d_wready pulses exactly 8 times, aligned with m_ready.
  - m_wdata follows d_wdata; d_done follows the 8th accepted beat.
- **Contention:** i_req and d_req held continuously from reset.
  - Grants in order I, D, I, D.
  - Each burst gap is exactly 2 cycles of m_req = 0.
- **Ignored strobes:** m_rvalid pulses during a write burst; m_ready pulses during a read burst.
  - beat_cnt is unaffected and neither rvalid goes high.
- **Reset mid-burst:** rst after beat 3 of an I refill.
  - All outputs are 0 the next cycle, with no i_done.
  - A fresh i_req restarts from beat 0 with m_addr re-latched.

Source files
------------

// File: rtl/l1_refill_arbiter_pkg.sv
// Shared L1 cache definitions used by the refill arbiter and the cache refill engines.
package l1_refill_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Bit position in request/grant vectors matches the encoding.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    localparam int L1_BEATS         = 8;
    localparam int L1_BEAT_WIDTH    = 32;
    localparam int L1_LINE_OFFSET_W = $clog2(L1_BEATS * L1_BEAT_WIDTH / 8);

    // Number of byte-offset bits inside one cache line.
    function automatic int line_offset_w(input int beats, input int data_width);
        return $clog2(beats * data_width / 8);
    endfunction

endpackage

// File: rtl/l1_refill_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: the requester not granted last wins a tie.
module l1_refill_arbiter_rr_arbiter2
    import l1_refill_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  arb_owner_t update_owner,
    output logic [1:0] grant
);

    arb_owner_t last_owner_reg;
    logic       last_bit;

    // Remember who owned the port most recently; D at reset so I wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= OWNER_D;
        end else if (update) begin
            last_owner_reg <= update_owner;
        end
    end

    assign last_bit = (last_owner_reg == OWNER_D);

    // A requester wins when alone, or when the other also asks but won last time.
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign grant[gi] = req[gi] && (!req[1-gi] || (last_bit != 1'(gi)));
    end

endmodule

// File: rtl/l1_refill_arbiter.sv
// Shares the external memory port between the L1 I-cache refill engine and the
// L1 D-cache miss/writeback engine, one whole cache-line burst at a time.
module l1_refill_arbiter
    import l1_refill_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = L1_BEAT_WIDTH,
    parameter int BEATS      = L1_BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wready,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    localparam int OFF_W = line_offset_w(BEATS, DATA_WIDTH);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t            state_reg;
    arb_owner_t            owner_reg;
    logic [CNT_W-1:0]      beat_cnt_reg;
    logic                  m_req_reg;
    logic                  m_we_reg;
    logic [ADDR_WIDTH-1:0] m_addr_reg;
    logic                  i_done_reg;
    logic                  d_done_reg;

    logic [1:0] grant;
    logic       busy;
    logic       owner_is_i;
    logic       beat;
    logic       rd_beat;

    l1_refill_arbiter_rr_arbiter2 u_rr (
        .clk          (clk),
        .rst          (rst),
        .req          ({d_req, i_req}),
        .update       (state_reg == DONE),
        .update_owner (owner_reg),
        .grant        (grant)
    );

    assign busy       = (state_reg == BUSY);
    assign owner_is_i = (owner_reg == OWNER_I);
    // Only the strobe matching the burst direction advances the burst.
    assign beat       = busy && (m_we_reg ? m_ready : m_rvalid);
    assign rd_beat    = busy && !m_we_reg && m_rvalid;

    // Burst sequencing: grant in IDLE, count beats in BUSY, one-cycle done in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= OWNER_I;
            beat_cnt_reg <= '0;
            m_req_reg    <= 1'b0;
            m_we_reg     <= 1'b0;
            m_addr_reg   <= '0;
            i_done_reg   <= 1'b0;
            d_done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        owner_reg    <= grant[1] ? OWNER_D : OWNER_I;
                        m_we_reg     <= grant[1] && d_we;
                        m_addr_reg   <= (grant[1] ? d_addr : i_addr) & LINE_MASK;
                        beat_cnt_reg <= '0;
                        m_req_reg    <= 1'b1;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                        if (beat_cnt_reg == LAST_BEAT) begin
                            m_req_reg  <= 1'b0;
                            i_done_reg <= (owner_reg == OWNER_I);
                            d_done_reg <= (owner_reg == OWNER_D);
                            state_reg  <= DONE;
                        end
                    end
                end
                DONE: begin
                    i_done_reg <= 1'b0;
                    d_done_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign m_req    = m_req_reg;
    assign m_we     = m_we_reg;
    assign m_addr   = m_addr_reg;
    assign i_done   = i_done_reg;
    assign d_done   = d_done_reg;

    // Data paths are pass-through while a burst is active and quiet otherwise.
    assign m_wdata  = busy ? d_wdata : '0;
    assign d_wready = busy && m_we_reg && m_ready;
    assign i_rvalid = rd_beat && owner_is_i;
    assign d_rvalid = rd_beat && !owner_is_i;
    assign i_rdata  = (busy && owner_is_i) ? m_rdata : '0;
    assign d_rdata  = (busy && !owner_is_i) ? m_rdata : '0;

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Directed self-checking bench for the L1 refill arbiter.
module tb_l1_refill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l1_refill_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BEATS      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_done   (i_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wready (d_wready),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Eight zero-wait read beats for an I refill already in BUSY, then done.
    task automatic i_read(input logic [31:0] base);
        for (int k = 0; k < 8; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(k);
            #1;
            chk("i_rvalid", {31'b0, i_rvalid}, 32'd1);
            chk("i_rdata", i_rdata, base + 32'(k));
            chk("d_rvalid", {31'b0, d_rvalid}, 32'd0);
            chk("i_done_early", {31'b0, i_done}, 32'd0);
            chk("m_req_busy", {31'b0, m_req}, 32'd1);
            tick();
        end
        m_rvalid = 1'b0;
        #1;
        chk("i_done", {31'b0, i_done}, 32'd1);
        chk("d_done_idle", {31'b0, d_done}, 32'd0);
        chk("m_req_done", {31'b0, m_req}, 32'd0);
        i_req = 1'b0;
        tick();
        #1;
        chk("i_done_pulse", {31'b0, i_done}, 32'd0);
        chk("m_req_idle", {31'b0, m_req}, 32'd0);
        $display("burst I read base=%h done", base);
    endtask

    // One D burst from IDLE. Real beats land on even cycles; with noise set,
    // the opposite-direction strobe pulses on the odd cycles.
    task automatic d_burst(input logic we, input logic [31:0] addr, input logic noise);
        int beats;
        int cyc;
        int pulses;
        logic real_beat;
        beats  = 0;
        cyc    = 0;
        pulses = 0;
        d_req  = 1'b1;
        d_we   = we;
        d_addr = addr;
        #1;
        chk("d_m_req_idle", {31'b0, m_req}, 32'd0);
        tick();
        #1;
        chk("d_m_req", {31'b0, m_req}, 32'd1);
        chk("d_m_we", {31'b0, m_we}, {31'b0, we});
        chk("d_m_addr", m_addr, addr & 32'hFFFF_FFE0);
        while (beats < 8 && cyc < 40) begin
            real_beat = (cyc % 2 == 0);
            m_ready   = we ? real_beat : (noise && !real_beat);
            m_rvalid  = we ? (noise && !real_beat) : real_beat;
            d_wdata   = 32'hD000 + 32'(beats);
            m_rdata   = 32'hE000 + 32'(beats);
            #1;
            chk("d_wready", {31'b0, d_wready}, {31'b0, we && real_beat});
            chk("m_wdata", m_wdata, 32'hD000 + 32'(beats));
            chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, !we && real_beat});
            chk("i_rvalid_d", {31'b0, i_rvalid}, 32'd0);
            chk("d_m_req_busy", {31'b0, m_req}, 32'd1);
            chk("d_done_early", {31'b0, d_done}, 32'd0);
            if (!we && real_beat) chk("d_rdata", d_rdata, 32'hE000 + 32'(beats));
            if (d_wready) pulses++;
            if (real_beat) beats++;
            cyc++;
            tick();
        end
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        #1;
        chk("d_wready_count", 32'(pulses), we ? 32'd8 : 32'd0);
        chk("d_done", {31'b0, d_done}, 32'd1);
        chk("i_done_d", {31'b0, i_done}, 32'd0);
        chk("d_m_req_done", {31'b0, m_req}, 32'd0);
        d_req = 1'b0;
        tick();
        #1;
        chk("d_done_pulse", {31'b0, d_done}, 32'd0);
        $display("burst D we=%0d addr=%h noise=%0d cycles=%0d done", we, addr, noise, cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = 32'hCAFE_F00D;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'hDEAD_BEEF;
        tick();
        tick();
        #1;
        chk("rst_m_req", {31'b0, m_req}, 32'd0);
        chk("rst_m_we", {31'b0, m_we}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_strobes", {26'b0, i_rvalid, d_rvalid, d_wready, i_done, d_done, 1'b0}, 32'd0);
        $display("reset checked");
        rst = 1'b0;

        // Single I refill
        i_req  = 1'b1;
        i_addr = 32'h0000_1234;
        #1;
        chk("i_m_req_idle", {31'b0, m_req}, 32'd0);
        tick();
        #1;
        chk("i_m_req", {31'b0, m_req}, 32'd1);
        chk("i_m_addr", m_addr, 32'h0000_1220);
        chk("i_m_we", {31'b0, m_we}, 32'd0);
        i_read(32'd0);

        // D writeback with m_ready toggling 1,0,1,...
        d_burst(1'b1, 32'h8000_0047, 1'b0);
        // Ignored strobes: m_rvalid during a write, m_ready during a read
        d_burst(1'b1, 32'h0000_3F00, 1'b1);
        d_burst(1'b0, 32'h1234_567F, 1'b1);

        // Contention held from reset: I, D, I, D with 2-cycle gaps
        rst      = 1'b1;
        i_req    = 1'b1;
        d_req    = 1'b1;
        d_we     = 1'b0;
        i_addr   = 32'h0000_0100;
        d_addr   = 32'h0000_0200;
        tick();
        rst = 1'b0;
        #1;
        chk("ct_idle", {31'b0, m_req}, 32'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            logic exp_i;
            exp_i = (b % 2 == 0);
            #1;
            chk("ct_m_req", {31'b0, m_req}, 32'd1);
            chk("ct_m_addr", m_addr, exp_i ? 32'h0000_0100 : 32'h0000_0200);
            for (int k = 0; k < 8; k++) begin
                m_rvalid = 1'b1;
                m_rdata  = 32'h100 * 32'(b) + 32'(k);
                #1;
                chk("ct_i_rvalid", {31'b0, i_rvalid}, {31'b0, exp_i});
                chk("ct_d_rvalid", {31'b0, d_rvalid}, {31'b0, !exp_i});
                tick();
            end
            m_rvalid = 1'b0;
            #1;
            chk("ct_m_req_gap1", {31'b0, m_req}, 32'd0);
            chk("ct_i_done", {31'b0, i_done}, {31'b0, exp_i});
            chk("ct_d_done", {31'b0, d_done}, {31'b0, !exp_i});
            tick();
            #1;
            chk("ct_m_req_gap2", {31'b0, m_req}, 32'd0);
            tick();
            $display("contention burst %0d owner=%s", b, exp_i ? "I" : "D");
        end
        i_req = 1'b0;
        d_req = 1'b0;
        // Last burst belonged to D and both dropped now, so the grant already
        // sampled above is an I burst; drain it.
        #1;
        chk("ct_tail_m_addr", m_addr, 32'h0000_0100);
        i_req = 1'b1;
        i_read(32'h0000_0700);

        // Reset mid-burst after beat 3 of an I refill
        i_req  = 1'b1;
        i_addr = 32'h2000_0F00;
        tick();
        #1;
        chk("rm_m_req", {31'b0, m_req}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'h40 + 32'(k);
            tick();
        end
        m_rvalid = 1'b0;
        rst      = 1'b1;
        tick();
        rst    = 1'b0;
        i_addr = 32'h0000_2345;
        #1;
        chk("rm_m_req_rst", {31'b0, m_req}, 32'd0);
        chk("rm_m_addr_rst", m_addr, 32'd0);
        chk("rm_i_done_rst", {31'b0, i_done}, 32'd0);
        chk("rm_i_rvalid_rst", {31'b0, i_rvalid}, 32'd0);
        tick();
        #1;
        chk("rm_i_done_after", {31'b0, i_done}, 32'd0);
        chk("rm_restart_req", {31'b0, m_req}, 32'd1);
        chk("rm_restart_addr", m_addr, 32'h0000_2340);
        i_read(32'h0000_0050);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
